// File: rtl/onehot_ring_decoder.sv
// -----------------------------------------------------------------------------
// onehot_ring_decoder
//
// Accepts a 4-bit binary code over a valid/ready handshake and decodes it into
// a registered 16-bit one-hot ring. Once loaded, the ring can be free-run. It
// then advances one position per clock, so a ring counter can be preset to any
// position 0..15. The registered binary position and a wrap pulse are also
// emitted.
//
// Parameters
//   RESET_LOADED  0: leave reset empty (Q=0); 1: leave reset holding RESET_CODE
//   RESET_CODE    code preloaded when RESET_LOADED=1
//
// Ports
//   clk_i        clock, all state changes on rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   in_code_i is offered
//   in_ready_o   code can be accepted this cycle (combinational, low in run)
//   in_code_i    binary code, bit [0] is the MSB
//   start_i      request free-run (honoured while holding only)
//   stop_i       request halt (honoured while running only, wins over start)
//   q_o          one-hot ring, q_o[i]=1 means position i
//   c_o          registered binary of the current position, bit [0] is the MSB
//   out_valid_o  q_o/c_o hold a valid position
//   wrap_o       one-cycle pulse after a ring advance from position 15 to 0
// -----------------------------------------------------------------------------
module onehot_ring_decoder #(
   parameter bit         RESET_LOADED = 1'b0,
   parameter logic [0:3] RESET_CODE   = 4'b0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [0:3]  in_code_i,
   input  logic        start_i,
   input  logic        stop_i,
   output logic [0:15] q_o,
   output logic [0:3]  c_o,
   output logic        out_valid_o,
   output logic        wrap_o
);

   typedef enum logic [1:0] {
      StEmpty,
      StHold,
      StRun
   } state_e;

   function automatic logic [0:15] decode(input logic [0:3] code);
      logic [0:15] oh;
      oh       = '0;
      oh[code] = 1'b1;
      return oh;
   endfunction

   localparam state_e      ResetState = RESET_LOADED ? StHold : StEmpty;
   localparam logic [0:15] ResetQ     = RESET_LOADED ? decode(RESET_CODE) : 16'h0000;
   localparam logic [0:3]  ResetC     = RESET_LOADED ? RESET_CODE : 4'b0000;
   localparam logic        ResetValid = RESET_LOADED;

   state_e      state_q, state_d;
   logic [0:15] q_q, q_d;
   logic [0:3]  c_q, c_d;
   logic        valid_q, valid_d;
   logic        wrap_q, wrap_d;
   logic        load;

   assign in_ready_o = (state_q != StRun);
   assign load       = in_valid_i & in_ready_o;

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      c_d     = c_q;
      valid_d = valid_q;
      wrap_d  = 1'b0;

      unique case (state_q)
         StEmpty, StHold: begin
            // A load takes priority over start; start is dropped on that edge.
            if (load) begin
               q_d     = decode(in_code_i);
               c_d     = in_code_i;
               valid_d = 1'b1;
               state_d = StHold;
            end else if ((state_q == StHold) && start_i) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (stop_i) begin
               state_d = StHold;
            end else begin
               // Rotate toward higher positions; position 15 wraps to 0.
               q_d    = {q_q[15], q_q[0:14]};
               c_d    = c_q + 4'd1;
               wrap_d = q_q[15];
            end
         end
         default: begin
            state_d = StEmpty;
            q_d     = '0;
            c_d     = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ResetState;
         q_q     <= ResetQ;
         c_q     <= ResetC;
         valid_q <= ResetValid;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         c_q     <= c_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   assign q_o         = q_q;
   assign c_o         = c_q;
   assign out_valid_o = valid_q;
   assign wrap_o      = wrap_q;

endmodule

// File: doc/onehot_ring_decoder.md
Name: onehot_ring_decoder

Overview:
- Inverse of the one-hot-to-binary encoder: takes a 4-bit binary code through a valid/ready handshake and decodes it into a registered 16-bit one-hot ring.
- The ring can then be free-run, advancing one position per clock, so a counter's position can be preset to any of 0..15.
- Also emits the registered binary position, for loop-back checks against the encoder, and a wrap pulse.

Parameters:
- RESET_LOADED, 0: 0 = come out of reset EMPTY with Q all-zero; 1 = come out of reset in HOLD with Q decoded from RESET_CODE.
- RESET_CODE, 4'b0000: code preloaded when RESET_LOADED=1.

Ports:
- CLK  input  1  clock; all state changes on posedge.
- RST_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  IN_CODE is offered.
- IN_READY  output  1  block can accept a code this cycle.
- IN_CODE  input  [0:3]  binary code; IN_CODE[0] is the MSB.
- START  input  1  request free-run (honoured in HOLD only).
- STOP  input  1  request halt (honoured in RUN only).
- Q  output  [0:15]  one-hot ring; Q[i]=1 means position i.
- C  output  [0:3]  registered binary of the current position; C[0] is the MSB.
- OUT_VALID  output  1  Q and C hold a valid position.
- WRAP  output  1  one-cycle pulse on a ring advance from position 15 to position 0.

Behaviour:
- States: EMPTY, HOLD, RUN.
- Reset (async, RST_N=0):
  - RESET_LOADED=0: state=EMPTY, Q=16'b0, C=0, OUT_VALID=0, WRAP=0.
  - RESET_LOADED=1: state=HOLD, Q one-hot at RESET_CODE, C=RESET_CODE, OUT_VALID=1, WRAP=0.
  - Mid-operation reset overrides everything immediately, without waiting for a clock edge.
- IN_READY is combinational from state: 1 in EMPTY and HOLD, 0 in RUN.
- Load happens when IN_VALID & IN_READY at a posedge. On that edge: Q <= one-hot(IN_CODE), C <= IN_CODE, OUT_VALID <= 1, state <= HOLD. Latency is one edge.
- Example: IN_CODE=4'b1010 loads Q[10]=1 and all other bits 0.
- EMPTY: START and STOP are ignored. Only a load leaves EMPTY.
- HOLD:
  - Q and C hold.
  - START=1 with no load on that edge: state <= RUN. Q does not advance on this edge.
  - Load and START together: the load wins and START is dropped.
  - STOP is ignored.
- RUN, on each posedge:
  - STOP=0: Q[i] <= Q[i-1] for i=1..15, Q[0] <= Q[15]; C <= C+1 modulo 16.
  - STOP=1: no advance on that edge; state <= HOLD.
  - START and STOP together in RUN: STOP wins.
  - IN_VALID in RUN is not accepted. The source must hold it until IN_READY returns.
- WRAP <= 1 exactly on a RUN advance where Q[15] was 1 (C goes 15 -> 0); otherwise WRAP <= 0. Loading code 0 does not pulse WRAP.
- Invariants:
  - OUT_VALID=1 implies Q is exactly one-hot and the encoded Q equals C.
  - OUT_VALID=0 implies Q=0 and C=0.
- All outputs are registered except IN_READY. WRAP, Q and C change only on posedge or on reset.

Test Plan:
- Reset with RESET_LOADED=0, RST_N low then high -> Q=0, C=0, OUT_VALID=0, IN_READY=1. START pulse -> state stays EMPTY, Q=0.
- Load IN_CODE=4'b0011 in EMPTY -> next edge Q[3]=1 only, C=3, OUT_VALID=1. Then load 4'b1111 in HOLD -> Q[15]=1, C=15.
- From HOLD at C=14, START for 1 cycle, then 3 RUN edges -> C = 15, 0, 1. WRAP=1 only in the cycle after the 15->0 edge. IN_READY=0 throughout RUN.
- In RUN at C=5: assert IN_VALID with 4'b1001 and STOP together -> code not accepted, C stays 5, state HOLD. On the following edge with IN_READY=1, the code is accepted -> C=9.
- In HOLD: assert load and START on the same edge -> load taken, state HOLD, no advance. Separately in RUN, assert START+STOP -> halts.
- Run 20 edges from code 0, then pull RST_N low between edges -> outputs go to reset values immediately. Loop-back through the encoder matches C on every cycle before reset.
